// File: rtl/disp_scheduler.sv
// disp_scheduler
//   Display arbiter for the 8-digit seven-segment multiplexer. By default the
//   stopwatch owns the digits. ASCII bytes from the UART receiver are
//   assembled into an edit buffer. A carriage return commits that buffer as
//   the message, which then owns the display for HOLD_TICKS tick pulses.
//
//   Optional build macro: DISP_BLINK_EN. When it is defined, a displayed
//   message blinks with a half-period of BLINK_TICKS ticks.
//
// Ports:
//   clk         system clock
//   rst         synchronous, active-high reset
//   tick        one-clk pulse, nominally 1 ms
//   sw_bcd      stopwatch digits; nibble k drives digit k (digit 0 is rightmost)
//   sw_dp       stopwatch decimal points; bit k belongs to digit k
//   rx_valid    one-clk strobe qualifying rx_data
//   rx_data     received ASCII byte
//   dig0..dig7  digit codes {dp, value}; value 4'hF is blank
//   msg_active  high while the message owns the display

module disp_scheduler #(
    parameter int HOLD_TICKS  = 2000,
    parameter int TCW         = 16,
    parameter int BLINK_TICKS = 250
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic [31:0] sw_bcd,
    input  logic [7:0]  sw_dp,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic [4:0]  dig0,
    output logic [4:0]  dig1,
    output logic [4:0]  dig2,
    output logic [4:0]  dig3,
    output logic [4:0]  dig4,
    output logic [4:0]  dig5,
    output logic [4:0]  dig6,
    output logic [4:0]  dig7,
    output logic        msg_active
);

    // Elaboration-time parameter sanity checks
    if (HOLD_TICKS < 1) begin : g_bad_hold
        $error("HOLD_TICKS must be at least 1");
    end
    if ((64'd1 << TCW) <= 64'(HOLD_TICKS)) begin : g_bad_tcw
        $error("TCW too narrow for HOLD_TICKS");
    end
    if (BLINK_TICKS < 1) begin : g_bad_blink
        $error("BLINK_TICKS must be at least 1");
    end

    localparam logic [4:0] BLANK = 5'h0F;

    typedef enum logic {
        SHOW_SW,
        SHOW_MSG
    } state_t;

    state_t           state, state_n;
    logic [4:0]       ebuf    [8];
    logic [4:0]       ebuf_n  [8];
    logic [4:0]       msg     [8];
    logic [4:0]       msg_n   [8];
    logic [4:0]       dig_q   [8];
    logic [4:0]       dig_n   [8];
    logic [TCW-1:0]   cnt, cnt_n;
    logic             show_n;

    // Received-byte classification
    logic is_digit, is_space, is_dot, is_esc, commit;

    always_comb begin
        is_digit = rx_valid && (rx_data >= 8'h30) && (rx_data <= 8'h39);
        is_space = rx_valid && (rx_data == 8'h20);
        is_dot   = rx_valid && (rx_data == 8'h2E);
        is_esc   = rx_valid && (rx_data == 8'h1B);
        commit   = rx_valid && (rx_data == 8'h0D);
    end

    // Edit buffer, message register, hold counter and next state
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        ebuf_n  = ebuf;
        msg_n   = msg;

        if (is_digit || is_space) begin
            for (int unsigned k = 1; k < 8; k++) begin
                ebuf_n[k] = ebuf[k-1];
            end
            ebuf_n[0] = is_digit ? {1'b0, rx_data[3:0]} : BLANK;
        end else if (is_dot) begin
            ebuf_n[0][4] = 1'b1;
        end else if (is_esc) begin
            for (int unsigned k = 0; k < 8; k++) begin
                ebuf_n[k] = BLANK;
            end
        end else if (commit) begin
            msg_n = ebuf;
            for (int unsigned k = 0; k < 8; k++) begin
                ebuf_n[k] = BLANK;
            end
            cnt_n   = TCW'(HOLD_TICKS);
            state_n = SHOW_MSG;
        end

        // A commit in the same cycle swallows the tick
        if (!commit && tick && (state == SHOW_MSG)) begin
            if (cnt == TCW'(1)) begin
                cnt_n   = '0;
                state_n = SHOW_SW;
            end else begin
                cnt_n = cnt - TCW'(1);
            end
        end
    end

`ifdef DISP_BLINK_EN
    localparam int BCW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    logic           phase, phase_n;   // 1 = visible
    logic [BCW-1:0] bcnt, bcnt_n;

    always_comb begin
        phase_n = phase;
        bcnt_n  = bcnt;
        if (commit) begin
            phase_n = 1'b1;
            bcnt_n  = '0;
        end else if (tick && (state == SHOW_MSG)) begin
            if (bcnt == BCW'(BLINK_TICKS - 1)) begin
                bcnt_n  = '0;
                phase_n = ~phase;
            end else begin
                bcnt_n = bcnt + BCW'(1);
            end
        end
        show_n = phase_n;
    end
`else
    always_comb begin
        show_n = 1'b1;
    end
`endif

    // Outputs are computed from the next state so msg_active and the
    // digits change on the same edge.
    always_comb begin
        for (int unsigned k = 0; k < 8; k++) begin
            if (state_n == SHOW_MSG) begin
                dig_n[k] = show_n ? msg_n[k] : BLANK;
            end else begin
                dig_n[k] = {sw_dp[k], sw_bcd[4*k +: 4]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= SHOW_SW;
            cnt        <= '0;
            msg_active <= 1'b0;
            for (int unsigned k = 0; k < 8; k++) begin
                ebuf[k]  <= BLANK;
                msg[k]   <= BLANK;
                dig_q[k] <= BLANK;
            end
`ifdef DISP_BLINK_EN
            phase <= 1'b1;
            bcnt  <= '0;
`endif
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            msg_active <= (state_n == SHOW_MSG);
            ebuf       <= ebuf_n;
            msg        <= msg_n;
            dig_q      <= dig_n;
`ifdef DISP_BLINK_EN
            phase <= phase_n;
            bcnt  <= bcnt_n;
`endif
        end
    end

    assign dig0 = dig_q[0];
    assign dig1 = dig_q[1];
    assign dig2 = dig_q[2];
    assign dig3 = dig_q[3];
    assign dig4 = dig_q[4];
    assign dig5 = dig_q[5];
    assign dig6 = dig_q[6];
    assign dig7 = dig_q[7];

endmodule
